// File: rtl/mac_job_sched_pkg.sv
// Shared types for the MAC job scheduler.
// Defines the slot lifecycle and the engine sequencing states.
package mac_package;

  localparam int MAC_SCHED_N_CONTEXT = 2;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_ACQ,
    SLOT_QUEUED,
    SLOT_RUN
  } slot_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/mac_sched_ctx_fifo.sv
// FIFO of committed slot ids, depth equal to the number of slots.
// Push and pop may both happen in one cycle; clear empties it.
module mac_sched_ctx_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    cnt_d = cnt_q + (PW+1)'(push_i) - (PW+1)'(do_pop);
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_job_sched.sv
// Hands job slots to cores round-robin, queues commits and sequences
// one engine job at a time, routing completions back to the owner.
module mac_job_sched
  import mac_package::*;
#(
  parameter  int N_CORES   = 2,
  parameter  int N_CONTEXT = MAC_SCHED_N_CONTEXT,
  localparam int CTX_W     = $clog2(N_CONTEXT)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [N_CORES-1:0]              acq_req_i,
  output logic [N_CORES-1:0]              acq_gnt_o,
  output logic [CTX_W-1:0]                acq_ctx_o,
  input  logic [N_CORES-1:0]              commit_i,
  input  logic [N_CORES-1:0][CTX_W-1:0]   commit_ctx_i,
  output logic [N_CORES-1:0]              commit_ack_o,
  output logic                            err_o,
  output logic                            start_o,
  output logic [CTX_W-1:0]                eng_ctx_o,
  input  logic                            done_i,
  output logic [N_CORES-1:0]              evt_o,
  output logic                            busy_o
);

  localparam int OWN_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  slot_state_t          slot_q  [N_CONTEXT];
  slot_state_t          slot_d  [N_CONTEXT];
  logic [OWN_W-1:0]     owner_q [N_CONTEXT];
  logic [OWN_W-1:0]     owner_d [N_CONTEXT];
  logic [OWN_W-1:0]     rr_q, rr_d;
  sched_state_t         state_q, state_d;
  logic [N_CORES-1:0]   gnt_q, gnt_d, ack_q, ack_d, evt_q, evt_d;
  logic [CTX_W-1:0]     ctx_q, ctx_d, eng_ctx_q, eng_ctx_d;
  logic                 err_q, err_d, start_q, start_d;

  logic                 win_vld, free_vld, cm_vld;
  logic [OWN_W-1:0]     win, cm_core;
  logic [CTX_W-1:0]     free_idx, cctx, fifo_head;
  logic                 push, pop, fifo_empty;
  int                   c_idx;

  mac_sched_ctx_fifo #(
    .DEPTH (N_CONTEXT),
    .W     (CTX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (cctx),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  always_comb begin
    slot_d    = slot_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    state_d   = state_q;
    ctx_d     = ctx_q;
    eng_ctx_d = eng_ctx_q;
    gnt_d     = '0;
    ack_d     = '0;
    evt_d     = '0;
    err_d     = 1'b0;
    start_d   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    win_vld   = 1'b0;
    win       = '0;
    free_vld  = 1'b0;
    free_idx  = '0;
    cm_vld    = 1'b0;
    cm_core   = '0;
    cctx      = '0;
    c_idx     = 0;

    for (int i = 0; i < N_CORES; i++) begin
      c_idx = (int'(rr_q) + i) % N_CORES;
      if (!win_vld && acq_req_i[c_idx]) begin
        win_vld = 1'b1;
        win     = OWN_W'(c_idx);
      end
    end
    for (int i = 0; i < N_CONTEXT; i++) begin
      if (!free_vld && slot_q[i] == SLOT_FREE) begin
        free_vld = 1'b1;
        free_idx = CTX_W'(i);
      end
    end
    if (win_vld && free_vld) begin
      gnt_d[win]        = 1'b1;
      ctx_d             = free_idx;
      slot_d[free_idx]  = SLOT_ACQ;
      owner_d[free_idx] = win;
      rr_d = (int'(win) == N_CORES - 1) ? '0 : win + OWN_W'(1);
    end

    // A core still holding commit during its ack cycle is not re-evaluated
    for (int i = 0; i < N_CORES; i++) begin
      if (!cm_vld && commit_i[i] && !ack_q[i]) begin
        cm_vld  = 1'b1;
        cm_core = OWN_W'(i);
      end
    end
    if (cm_vld) begin
      cctx           = commit_ctx_i[cm_core];
      ack_d[cm_core] = 1'b1;
      if (slot_q[cctx] == SLOT_ACQ && owner_q[cctx] == cm_core) begin
        slot_d[cctx] = SLOT_QUEUED;
        push         = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        state_d           = START;
        start_d           = 1'b1;
        eng_ctx_d         = fifo_head;
        pop               = 1'b1;
        slot_d[fifo_head] = SLOT_RUN;
      end
      START: state_d = RUN;
      RUN: if (done_i) begin
        state_d                     = DONE;
        evt_d[owner_q[eng_ctx_q]]   = 1'b1;
        slot_d[eng_ctx_q]           = SLOT_FREE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      for (int i = 0; i < N_CONTEXT; i++) begin
        slot_d[i]  = SLOT_FREE;
        owner_d[i] = '0;
      end
      rr_d      = '0;
      state_d   = IDLE;
      ctx_d     = '0;
      eng_ctx_d = '0;
      gnt_d     = '0;
      ack_d     = '0;
      evt_d     = '0;
      err_d     = 1'b0;
      start_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CONTEXT; i++) begin
        slot_q[i]  <= SLOT_FREE;
        owner_q[i] <= '0;
      end
      rr_q      <= '0;
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      evt_q     <= '0;
      ctx_q     <= '0;
      eng_ctx_q <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      evt_q     <= evt_d;
      ctx_q     <= ctx_d;
      eng_ctx_q <= eng_ctx_d;
      err_q     <= err_d;
      start_q   <= start_d;
    end
  end

  assign acq_gnt_o    = gnt_q;
  assign acq_ctx_o    = ctx_q;
  assign commit_ack_o = ack_q;
  assign err_o        = err_q;
  assign start_o      = start_q;
  assign eng_ctx_o    = eng_ctx_q;
  assign evt_o        = evt_q;
  assign busy_o       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mac_job_sched.sv
// Bench for mac_job_sched: directed stimulus, a queue-based reference
// model checked every cycle, and literal checks that pin the model.
module tb_mac_job_sched;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic [1:0]      acq_req;
  logic [1:0]      acq_gnt;
  logic [0:0]      acq_ctx;
  logic [1:0]      commit;
  logic [1:0][0:0] commit_ctx;
  logic [1:0]      ack;
  logic            err;
  logic            start;
  logic [0:0]      eng_ctx;
  logic            done;
  logic [1:0]      evt;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mac_job_sched #(
    .N_CORES   (2),
    .N_CONTEXT (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .acq_req_i    (acq_req),
    .acq_gnt_o    (acq_gnt),
    .acq_ctx_o    (acq_ctx),
    .commit_i     (commit),
    .commit_ctx_i (commit_ctx),
    .commit_ack_o (ack),
    .err_o        (err),
    .start_o      (start),
    .eng_ctx_o    (eng_ctx),
    .done_i       (done),
    .evt_o        (evt),
    .busy_o       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot status per id, owners, a job queue and
  // the engine's current job with its earliest done/next-start times.
  localparam int S_FREE = 0, S_ACQ = 1, S_QUE = 2, S_RUN = 3;
  int m_slot [2];
  int m_own  [2];
  int m_rr, job, start_cyc, ready_at, cyc;
  int mq[$];
  logic [1:0] exp_gnt, exp_ack, exp_evt;
  logic       exp_ctx, exp_err, exp_start, exp_eng, exp_busy;

  always @(posedge clk) begin : model
    int w, f, s, old [2];
    logic [1:0] n_gnt, n_ack, n_evt;
    logic n_err, n_start, pushed;
    cyc++;
    if (rst || clear) begin
      for (int i = 0; i < 2; i++) begin
        m_slot[i] = S_FREE;
        m_own[i]  = 0;
      end
      m_rr = 0; job = -1; start_cyc = 0; ready_at = 0;
      mq.delete();
      exp_gnt = 0; exp_ack = 0; exp_evt = 0; exp_ctx = 0;
      exp_err = 0; exp_start = 0; exp_eng = 0; exp_busy = 0;
    end else begin
      n_gnt = 0; n_ack = 0; n_evt = 0; n_err = 0; n_start = 0;
      pushed = 0; s = 0;
      for (int i = 0; i < 2; i++) old[i] = m_slot[i];
      w = -1;
      for (int i = 0; i < 2; i++)
        if (w < 0 && acq_req[(m_rr + i) % 2]) w = (m_rr + i) % 2;
      f = -1;
      for (int i = 0; i < 2; i++)
        if (f < 0 && old[i] == S_FREE) f = i;
      if (w >= 0 && f >= 0) begin
        n_gnt[w] = 1'b1;
        exp_ctx = f[0];
        m_slot[f] = S_ACQ;
        m_own[f] = w;
        m_rr = (w + 1) % 2;
      end
      for (int i = 0; i < 2; i++) begin
        if (n_ack == 0 && commit[i] && !exp_ack[i]) begin
          n_ack[i] = 1'b1;
          s = int'(commit_ctx[i]);
          if (old[s] == S_ACQ && m_own[s] == i) begin
            m_slot[s] = S_QUE;
            pushed = 1;
          end else begin
            n_err = 1;
          end
        end
      end
      if (job >= 0 && done && cyc >= start_cyc + 2) begin
        n_evt[m_own[job]] = 1'b1;
        m_slot[job] = S_FREE;
        job = -1;
        ready_at = cyc + 2;
      end else if (job < 0 && mq.size() > 0 && cyc >= ready_at) begin
        job = mq.pop_front();
        n_start = 1;
        exp_eng = job[0];
        m_slot[job] = S_RUN;
        start_cyc = cyc;
      end
      if (pushed) mq.push_back(s);
      exp_gnt = n_gnt; exp_ack = n_ack; exp_evt = n_evt;
      exp_err = n_err; exp_start = n_start;
      exp_busy = (job >= 0) || (mq.size() > 0) || (n_evt != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_gnt", 32'(acq_gnt), 32'(exp_gnt));
      if (exp_gnt != 0) chk("m_ctx", 32'(acq_ctx), 32'(exp_ctx));
      chk("m_ack", 32'(ack), 32'(exp_ack));
      chk("m_err", 32'(err), 32'(exp_err));
      chk("m_start", 32'(start), 32'(exp_start));
      chk("m_eng", 32'(eng_ctx), 32'(exp_eng));
      chk("m_evt", 32'(evt), 32'(exp_evt));
      chk("m_busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic tk();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; clear = 0; acq_req = 0; commit = 0;
    commit_ctx = '0; done = 0;
    repeat (3) tk();
    chk_en = 1;
    rst = 0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tk();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_out", 32'({acq_gnt, ack, err, start, evt}), 0);
    end

    // 2: single job end to end
    acq_req = 2'b01; tk();
    chk("t2_gnt", 32'(acq_gnt), 1); chk("t2_ctx", 32'(acq_ctx), 0);
    acq_req = 0;
    commit = 2'b01; commit_ctx[0] = 1'b0; tk();
    chk("t2_ack", 32'(ack), 1); chk("t2_err", 32'(err), 0);
    commit = 0; tk();
    chk("t2_start", 32'(start), 1); chk("t2_eng", 32'(eng_ctx), 0);
    repeat (20) tk();
    done = 1; tk(); done = 0;
    chk("t2_evt", 32'(evt), 1);
    tk();
    chk("t2_idle", 32'(busy), 0);
    clear = 1; tk(); clear = 0;

    // 3: both cores request, two slots
    acq_req = 2'b11; tk();
    chk("t3_g0", 32'(acq_gnt), 1); chk("t3_c0", 32'(acq_ctx), 0);
    tk();
    chk("t3_g1", 32'(acq_gnt), 2); chk("t3_c1", 32'(acq_ctx), 1);
    tk(); chk("t3_g2", 32'(acq_gnt), 0);
    tk(); chk("t3_g3", 32'(acq_gnt), 0);
    acq_req = 0;

    // 4: foreign commit rejected
    commit = 2'b10; commit_ctx[1] = 1'b0; tk();
    chk("t4_ack", 32'(ack), 2); chk("t4_err", 32'(err), 1);
    commit = 0;
    repeat (3) begin
      tk(); chk("t4_nostart", 32'(start), 0);
    end

    // 5: two commits back to back, done during START ignored
    commit = 2'b10; commit_ctx[1] = 1'b1; tk();
    chk("t5_ack1", 32'(ack), 2); chk("t5_err1", 32'(err), 0);
    commit = 2'b01; commit_ctx[0] = 1'b0; tk();
    chk("t5_ack0", 32'(ack), 1);
    chk("t5_st1", 32'(start), 1); chk("t5_eng1", 32'(eng_ctx), 1);
    commit = 0; done = 1; tk(); done = 0;
    chk("t5_early", 32'(evt), 0);
    repeat (3) tk();
    done = 1; tk(); done = 0;
    chk("t5_evt1", 32'(evt), 2);
    tk();
    chk("t5_gap", 32'(start), 0); chk("t5_busy", 32'(busy), 1);
    tk();
    chk("t5_st0", 32'(start), 1); chk("t5_eng0", 32'(eng_ctx), 0);
    tk();
    done = 1; tk(); done = 0;
    chk("t5_evt0", 32'(evt), 1);
    tk();

    // 6a: done and acquire in the same cycle, all slots busy
    clear = 1; tk(); clear = 0;
    acq_req = 2'b01; tk();
    chk("t6_g0", 32'(acq_gnt), 1); chk("t6_c0", 32'(acq_ctx), 0);
    tk();
    chk("t6_g1", 32'(acq_gnt), 1); chk("t6_c1", 32'(acq_ctx), 1);
    acq_req = 0;
    commit = 2'b01; commit_ctx[0] = 1'b0; tk();
    chk("t6_ack", 32'(ack), 1);
    commit = 0; tk();
    chk("t6_st", 32'(start), 1);
    tk();
    acq_req = 2'b10; tk();
    chk("t6_full0", 32'(acq_gnt), 0);
    tk();
    chk("t6_full1", 32'(acq_gnt), 0);
    done = 1; tk(); done = 0;
    chk("t6_evt", 32'(evt), 1); chk("t6_nogn", 32'(acq_gnt), 0);
    tk();
    chk("t6_regn", 32'(acq_gnt), 2); chk("t6_rectx", 32'(acq_ctx), 0);
    acq_req = 0;

    // 6b: clear while running abandons the job
    commit = 2'b10; commit_ctx[1] = 1'b0; tk();
    chk("t6b_ack", 32'(ack), 2); chk("t6b_err", 32'(err), 0);
    commit = 0; tk();
    chk("t6b_st", 32'(start), 1);
    tk();
    chk("t6b_run", 32'(busy), 1);
    clear = 1; tk(); clear = 0;
    chk("t6b_busy", 32'(busy), 0); chk("t6b_evt", 32'(evt), 0);
    done = 1; tk(); done = 0;
    chk("t6b_noevt", 32'(evt), 0); chk("t6b_idle", 32'(busy), 0);
    repeat (3) tk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
